// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin writeback arbiter for the register file write port with pending-write scoreboard
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [5*NUM_REQ-1:0]      req_rd,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      issue_valid,
    input  logic [4:0]                issue_rd,
    output logic                      wr_en,
    output logic [4:0]                wr_rd,
    output logic [DATA_W-1:0]         wr_data,
    output logic [31:0]               pending
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   nxt_ptr;
    logic [NUM_REQ-1:0] hi_mask;
    logic [NUM_REQ-1:0] masked_valid;
    logic               transfer;
    logic [4:0]         sel_rd;
    logic [DATA_W-1:0]  sel_data;
    logic [31:0]        pending_nxt;

    // Requests at or above rr_ptr win first; otherwise wrap to the lowest valid index.
    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hi_mask[i] = (PTR_W'(i) >= rr_ptr);
        end
        masked_valid = req_valid & hi_mask;
        grant_idx    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) grant_idx = PTR_W'(i);
        end
        if (|masked_valid) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (masked_valid[i]) grant_idx = PTR_W'(i);
            end
        end
    end

    always_comb begin
        transfer  = (|req_valid) && !rst;
        req_ready = '0;
        sel_rd    = '0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (PTR_W'(i) == grant_idx) begin
                req_ready[i] = transfer;
                sel_rd       = req_rd[5*i +: 5];
                sel_data     = req_data[DATA_W*i +: DATA_W];
            end
        end
        nxt_ptr = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end

    // Set is applied after clear so a newer producer of the same register keeps it pending.
    always_comb begin
        pending_nxt = pending;
        if (transfer && (sel_rd != 5'd0)) pending_nxt[sel_rd] = 1'b0;
        if (issue_valid && (issue_rd != 5'd0)) pending_nxt[issue_rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr  <= '0;
            wr_en   <= 1'b0;
            wr_rd   <= '0;
            wr_data <= '0;
            pending <= '0;
        end else begin
            pending <= pending_nxt;
            wr_en   <= 1'b0;
            if (transfer) begin
                rr_ptr <= nxt_ptr;
                if (sel_rd != 5'd0) begin
                    wr_en   <= 1'b1;
                    wr_rd   <= sel_rd;
                    wr_data <= sel_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter against a behavioural model
module tb_regfile_wb_arbiter;

    localparam int N = 3;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [5*N-1:0]  req_rd;
    logic [32*N-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic          issue_valid;
    logic [4:0]    issue_rd;
    logic          wr_en;
    logic [4:0]    wr_rd;
    logic [31:0]   wr_data;
    logic [31:0]   pending;

    regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .wr_en(wr_en), .wr_rd(wr_rd), .wr_data(wr_data), .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] grant;
        logic [31:0]  pend;
        logic         wen;
        logic [4:0]   wrd;
        logic [31:0]  wdat;
    } rec_t;

    rec_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    // requester-side state: a request stays presented until it is granted
    bit          r_on  [N];
    logic [4:0]  r_rd  [N];
    logic [31:0] r_dat [N];

    // reference model state
    int          m_ptr;
    logic [31:0] m_pend;
    logic        m_wen;
    logic [4:0]  m_wrd;
    logic [31:0] m_wdat;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_pend = '0;
        m_wen  = 1'b0;
        m_wrd  = '0;
        m_wdat = '0;
    endtask

    // Drive one cycle's inputs, record the expected visible state, advance the model over the next edge.
    task automatic step(input bit do_rst, input bit iv, input logic [4:0] ird);
        rec_t r;
        int   g;
        rst         = do_rst;
        issue_valid = iv;
        issue_rd    = ird;
        for (int i = 0; i < N; i++) begin
            req_valid[i]        = r_on[i];
            req_rd[5*i +: 5]    = r_rd[i];
            req_data[32*i +: 32] = r_dat[i];
        end
        if (do_rst) model_reset();
        g = -1;
        if (!do_rst) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && r_on[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        r.grant = '0;
        if (g >= 0) r.grant[g] = 1'b1;
        r.pend = m_pend;
        r.wen  = m_wen;
        r.wrd  = m_wrd;
        r.wdat = m_wdat;
        sb.push_back(r);
        if (!do_rst) begin
            m_wen = 1'b0;
            if (g >= 0) begin
                m_ptr = (g + 1) % N;
                if (r_rd[g] != 0) begin
                    m_pend[r_rd[g]] = 1'b0;
                    m_wen  = 1'b1;
                    m_wrd  = r_rd[g];
                    m_wdat = r_dat[g];
                end
                r_on[g] = 1'b0;
            end
            if (iv && ird != 0) m_pend[ird] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input int i, input logic [4:0] rd, input logic [31:0] dat);
        r_on[i]  = 1'b1;
        r_rd[i]  = rd;
        r_dat[i] = dat;
    endtask

    initial begin : monitor
        rec_t r;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                r = sb.pop_front();
                chk("req_ready", 64'(req_ready), 64'(r.grant));
                chk("wr_en", 64'(wr_en), 64'(r.wen));
                chk("pending", 64'(pending), 64'(r.pend));
                if (r.wen) begin
                    chk("wr_rd", 64'(wr_rd), 64'(r.wrd));
                    chk("wr_data", 64'(wr_data), 64'(r.wdat));
                end
            end
        end
    end

    initial begin : stim
        for (int i = 0; i < N; i++) arm(i, 5'(i + 1), 32'h1000 + i);
        model_reset();
        rst = 1'b1;
        issue_valid = 1'b0;
        issue_rd = '0;
        req_valid = '0;
        req_rd = '0;
        req_data = '0;
        @(posedge clk);
        #1;
        // reset with every requester valid, then release
        step(1'b1, 1'b0, 5'd0);
        step(1'b0, 1'b0, 5'd0);
        // all three held valid: rotating grants
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < N; i++)
                if (!r_on[i]) arm(i, 5'($urandom_range(1, 31)), $urandom);
            step(1'b0, 1'b0, 5'd0);
        end
        for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 5'd0);
        // steer pointer to 2, then sparse requests across the wrap
        arm(1, 5'd9, 32'h0000_0009);
        step(1'b0, 1'b0, 5'd0);
        arm(0, 5'd10, 32'h0000_000A);
        step(1'b0, 1'b0, 5'd0);
        arm(2, 5'd11, 32'h0000_000B);
        step(1'b0, 1'b0, 5'd0);
        // x0 write is consumed silently; issue of x0 sets nothing
        arm(0, 5'd0, 32'hDEAD_BEEF);
        step(1'b0, 1'b1, 5'd0);
        step(1'b0, 1'b0, 5'd0);
        // scoreboard set, clear, and same-bit set-wins
        step(1'b0, 1'b1, 5'd5);
        arm(1, 5'd5, 32'h5555_5555);
        step(1'b0, 1'b0, 5'd0);
        step(1'b0, 1'b1, 5'd7);
        arm(2, 5'd7, 32'h7777_7777);
        step(1'b0, 1'b1, 5'd7);
        step(1'b0, 1'b1, 5'd5);
        step(1'b0, 1'b0, 5'd0);
        // reset while requests are pending and pending=0xA0
        arm(0, 5'd3, 32'h3333_3333);
        arm(1, 5'd4, 32'h4444_4444);
        step(1'b1, 1'b0, 5'd0);
        step(1'b0, 1'b0, 5'd0);
        step(1'b0, 1'b0, 5'd0);
        // randomized traffic with occasional resets
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if (!r_on[i] && $urandom_range(0, 1) == 1)
                    arm(i, 5'($urandom_range(0, 31)), $urandom);
            step($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)));
        end
        rst = 1'b0;
        for (int i = 0; i < N; i++) r_on[i] = 1'b0;
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
